// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - shared defaults and types for the data memory arbiter
//
// Contents:
//   DEF_ADDR_W / DEF_DATA_W : default address and data widths (32 x 8 memory)
//   arb_state_t             : arbiter FSM states (ARB, LOCK0, LOCK1)
//   port_id                 : one-bit requester index (0 = CPU, 1 = debug loader)

package data_mem_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

    typedef logic port_id;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin pick
//
// Ports:
//   req  in  2 : request vector, bit x = port x
//   last in  1 : port granted most recently (loses a tie)
//   gnt  out 2 : one-hot grant, or zero when nobody requests

module rr_arb2
    import data_mem_pkg::*;
(
    input  logic [1:0] req,
    input  port_id     last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last == 1'b1) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - two-port arbiter owning the 2^ADDR_W x DATA_W data memory
//
// Optional feature macro: DATA_MEM_ARB_LOCK_EN (adds lock_0/lock_1 and the LOCK0/LOCK1 states).
//
// Ports (x = 0, 1):
//   clock      in  1      : rising-edge clock
//   reset      in  1      : synchronous, active-low
//   req_x      in  1      : access request, held until gnt_x
//   we_x       in  1      : 1 = write, 0 = read
//   addr_x     in  ADDR_W : word address
//   wdata_x    in  DATA_W : write data
//   lock_x     in  1      : keep the grant for the next access (lock build only)
//   gnt_x      out 1      : access performed this cycle (combinational)
//   rvalid_x   out 1      : one-cycle pulse, read data valid
//   rdata_x    out DATA_W : read data, held until the next read on that port

module data_mem_arbiter
    import data_mem_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int LOCK_MAX = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_0,
    input  logic              we_0,
    input  logic [ADDR_W-1:0] addr_0,
    input  logic [DATA_W-1:0] wdata_0,
`ifdef DATA_MEM_ARB_LOCK_EN
    input  logic              lock_0,
    input  logic              lock_1,
`endif
    input  logic              req_1,
    input  logic              we_1,
    input  logic [ADDR_W-1:0] addr_1,
    input  logic [DATA_W-1:0] wdata_1,
    output logic              gnt_0,
    output logic              gnt_1,
    output logic              rvalid_0,
    output logic              rvalid_1,
    output logic [DATA_W-1:0] rdata_0,
    output logic [DATA_W-1:0] rdata_1
);

    localparam int DEPTH = 1 << ADDR_W;

    if (LOCK_MAX < 1) begin : g_bad_lock_max
        $error("data_mem_arbiter: LOCK_MAX must be at least 1");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    port_id            last;
    logic [1:0]        rr_gnt;
    logic [1:0]        gnt;

    rr_arb2 u_rr_arb2 (
        .req  ({req_1, req_0}),
        .last (last),
        .gnt  (rr_gnt)
    );

`ifdef DATA_MEM_ARB_LOCK_EN
    localparam int               CNT_W   = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

    arb_state_t       state, state_nxt;
    logic [CNT_W-1:0] lock_cnt, lock_cnt_nxt;

    // lock_cnt counts grants in the current locked burst, including the
    // unlocked grant that opened it; the burst ends on the grant that
    // brings it to LOCK_MAX so the other port is served next.
    always_comb begin
        gnt          = 2'b00;
        state_nxt    = state;
        lock_cnt_nxt = lock_cnt;
        case (state)
            ARB: begin
                gnt          = rr_gnt;
                lock_cnt_nxt = '0;
                if (LOCK_MAX > 1) begin
                    if (rr_gnt[0] && lock_0) begin
                        state_nxt    = LOCK0;
                        lock_cnt_nxt = CNT_W'(1);
                    end else if (rr_gnt[1] && lock_1) begin
                        state_nxt    = LOCK1;
                        lock_cnt_nxt = CNT_W'(1);
                    end
                end
            end
            LOCK0: begin
                gnt[0] = req_0;
                if (!req_0) begin
                    state_nxt    = ARB;
                    lock_cnt_nxt = '0;
                end else begin
                    lock_cnt_nxt = lock_cnt + 1'b1;
                    if (!lock_0 || lock_cnt_nxt == CNT_MAX) begin
                        state_nxt = ARB;
                    end
                end
            end
            LOCK1: begin
                gnt[1] = req_1;
                if (!req_1) begin
                    state_nxt    = ARB;
                    lock_cnt_nxt = '0;
                end else begin
                    lock_cnt_nxt = lock_cnt + 1'b1;
                    if (!lock_1 || lock_cnt_nxt == CNT_MAX) begin
                        state_nxt = ARB;
                    end
                end
            end
            default: begin
                state_nxt    = ARB;
                lock_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= ARB;
            lock_cnt <= '0;
        end else begin
            state    <= state_nxt;
            lock_cnt <= lock_cnt_nxt;
        end
    end
`else
    always_comb begin
        gnt = rr_gnt;
    end
`endif

    // Grants are suppressed while reset is low so nothing commits.
    assign gnt_0 = reset & gnt[0];
    assign gnt_1 = reset & gnt[1];

    // At most one grant, so the granted port's controls can be muxed by gnt_1.
    port_id            sel;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign sel       = gnt_1;
    assign sel_we    = sel ? we_1    : we_0;
    assign sel_addr  = sel ? addr_1  : addr_0;
    assign sel_wdata = sel ? wdata_1 : wdata_0;

    always_ff @(posedge clock) begin
        if (!reset) begin
            last     <= 1'b1;
            rvalid_0 <= 1'b0;
            rvalid_1 <= 1'b0;
            rdata_0  <= '0;
            rdata_1  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= DATA_W'(i);
            end
        end else begin
            rvalid_0 <= gnt_0 & ~we_0;
            rvalid_1 <= gnt_1 & ~we_1;
            if (gnt_0 | gnt_1) begin
                last <= sel;
                if (sel_we) begin
                    mem[sel_addr] <= sel_wdata;
                end
            end
            if (gnt_0 & ~we_0) begin
                rdata_0 <= mem[addr_0];
            end
            if (gnt_1 & ~we_1) begin
                rdata_1 <= mem[addr_1];
            end
        end
    end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Shares the 32×8 data memory between two requesters: port 0 (CPU load/store path) and port 1 (debug/console loader). It uses a round-robin arbiter with an optional lock for atomic read-modify-write sequences. The block owns the memory array, arbitrates one access per clock and returns read data one cycle after grant. It sits between the processor datapath and the data-memory storage, on the processor `clock` domain.

## Interface
Parameters:
- `ADDR_W`, default 5: address width; depth = 2^ADDR_W.
- `DATA_W`, default 8: data width.
- `LOCK_MAX`, default 4: maximum consecutive grants to one locked port (only used with the lock feature).

Ports (`x` = 0, 1):
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low.
- `req_x` in 1: access request; level, held until `gnt_x`.
- `we_x` in 1: 1 = write, 0 = read; valid while `req_x` is high.
- `addr_x` in ADDR_W: word address.
- `wdata_x` in DATA_W: write data.
- `lock_x` in 1: keep grant for the next access (lock feature only; ignored otherwise).
- `gnt_x` out 1: access performed this cycle.
- `rvalid_x` out 1: read data valid (cycle after a read grant).
- `rdata_x` out DATA_W: read data, held until the next read completes.

## Operation
- Exactly one access per cycle at most; `gnt_0 & gnt_1` is never 1.
- `gnt_x` is combinational from `req_x`, FSM state and priority pointer `last`. A write commits to `mem[addr_x]` at the rising edge ending the grant cycle.
- Read grant: `rdata_x <= mem[addr_x]` and `rvalid_x <= 1` at that edge. `rvalid_x` is a 1-cycle pulse.
- Read and write in the same cycle cannot occur (single grant), so there is no forwarding.
- Arbitration in `ARB` state:
  - only one port requesting: grant it;
  - both requesting: grant `~last`;
  - after any grant, `last <= granted port`.
- FSM states: `ARB`, `LOCK0`, `LOCK1`.
  - `ARB -> LOCKx` when `gnt_x & lock_x`; load `lock_cnt <= 1`.
  - In `LOCKx`, port x is granted if `req_x`; the other port is never granted. Each locked grant increments `lock_cnt`.
  - `LOCKx -> ARB` when `!req_x`, `!lock_x` on a grant, or `lock_cnt == LOCK_MAX` (forced release).
  - On forced release `last <= x`, so the other port wins next if requesting.
- Out-of-range addresses are impossible (full 2^ADDR_W decode); the address wraps naturally.
- Reset (`reset == 0` at an edge):
  - state `ARB`, `last <= 1` (port 0 has first priority);
  - `lock_cnt <= 0`;
  - `rvalid_x <= 0`, `rdata_x <= 0`;
  - `mem[i] <= i[DATA_W-1:0]` for all i.
  - While `reset` is low, `gnt_x` is forced 0 and no write commits.
- Reset mid-lock or mid-read: lock is dropped and any pending `rvalid` is cleared; the requester must re-request.

## Timing
- Write latency: 0 cycles to grant; data visible to a read granted in the next cycle.
- Read latency: `rvalid_x`/`rdata_x` one cycle after `gnt_x`.
- Back-to-back reads from the same port (via lock or sole requester) give one result per cycle.
- Contention: each port waits at most 1 grant (unlocked) or LOCK_MAX grants (locked).
- First edge with `reset == 1`: arbitration is active that cycle.

## Configuration
- `DATA_MEM_ARB_LOCK_EN` defined:
  - `lock_x` ports exist;
  - `LOCK0`/`LOCK1` states and `lock_cnt` are built.
- Not defined:
  - `lock_x` ports are removed;
  - FSM reduces to pure round-robin (`ARB` only);
  - `LOCK_MAX` is unused.

## Structure
- Shared package `data_mem_pkg`: `ADDR_W`/`DATA_W` defaults, FSM state enum (`ARB`, `LOCK0`, `LOCK1`), and the `port_id` typedef (1 bit).
- One sub-module, `rr_arb2`: 2-way round-robin pick from `req` and `last`. The lock FSM, counter and memory stay in the top.

## Test plan
- Reset check: release reset, read addr 7 on port 0 -> `gnt_0` same cycle; next cycle `rvalid_0 = 1`, `rdata_0 = 8'd7`.
- Contention: `req_0`, `req_1` both high from first cycle, reads at addrs 3 and 4 -> `gnt_0` cycle 0, `gnt_1` cycle 1; `rdata_0 = 3`, `rdata_1 = 4`; never both grants.
- Write then read: port 1 writes `8'hA5` to addr 31, then port 0 reads addr 31 next cycle -> `rdata_0 = 8'hA5`.
- Lock (macro on, `LOCK_MAX = 4`): port 0 holds `req`/`lock` while port 1 requests continuously -> exactly 4 consecutive `gnt_0`, then `gnt_1`.
- Lock release: port 0 drops `lock_0` on its 2nd grant -> `gnt_1` on the next cycle.
- Reset mid-lock: drive `reset` low during `LOCK0` for 1 cycle -> grants 0 that cycle, memory re-initialised (addr 31 reads 31), `gnt_0` first on next contention.
